// File: rtl/scu_isa_pkg.sv
// rtl/scu_isa_pkg.sv - SCU ISA field positions, widths, opcode and skid state types
package scu_isa_pkg;

  localparam int OPC_HI  = 31;
  localparam int OPC_LO  = 28;
  localparam int RD_HI   = 27;
  localparam int RD_LO   = 22;
  localparam int RS_HI   = 21;
  localparam int RS_LO   = 16;
  localparam int RT_HI   = 15;
  localparam int RT_LO   = 10;
  localparam int OPC_W   = 4;
  localparam int REG_W   = 6;
  // Contiguous span holding every decoded field, instr[OPC_HI:RT_LO].
  localparam int FIELD_W = OPC_HI - RT_LO + 1;

  typedef enum logic [OPC_W-1:0] {
    OPC_NOP  = 4'h0,
    OPC_ADD  = 4'h1,
    OPC_SUB  = 4'h2,
    OPC_AND  = 4'h3,
    OPC_OR   = 4'h4,
    OPC_XOR  = 4'h5,
    OPC_SHL  = 4'h6,
    OPC_SHR  = 4'h7,
    OPC_LD   = 4'h8,
    OPC_ST   = 4'h9,
    OPC_ADDI = 4'hA,
    OPC_BEQ  = 4'hB,
    OPC_BNE  = 4'hC,
    OPC_JMP  = 4'hD,
    OPC_JAL  = 4'hE,
    OPC_HALT = 4'hF
  } scu_opcode_e;

  // Encoded as {main_valid, skid_valid}; 2'b01 is unreachable.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b10,
    ST_TWO   = 2'b11
  } skid_state_e;

endpackage

// File: rtl/if_id_skid_reg_if.sv
// rtl/if_id_skid_reg_if.sv - fetch-side and decode-side handshake bundle of the IF/ID register
interface if_id_skid_reg_if #(
  parameter int PC_W    = 32,
  parameter int INSTR_W = 32
);
  logic               in_valid;
  logic               in_ready;
  logic [PC_W-1:0]    in_pc;
  logic [INSTR_W-1:0] in_instr;
  logic               out_valid;
  logic               out_ready;
  logic [PC_W-1:0]    out_pc;
  logic [INSTR_W-1:0] out_instr;
  logic [3:0]         out_opcode;
  logic [5:0]         out_rd;
  logic [5:0]         out_rs;
  logic [5:0]         out_rt;

  modport master (
    output in_valid, in_pc, in_instr, out_ready,
    input  in_ready, out_valid, out_pc, out_instr, out_opcode, out_rd, out_rs, out_rt
  );

  modport slave (
    input  in_valid, in_pc, in_instr, out_ready,
    output in_ready, out_valid, out_pc, out_instr, out_opcode, out_rd, out_rs, out_rt
  );
endinterface

// File: rtl/scu_field_split.sv
// rtl/scu_field_split.sv - combinational slicer of instr[OPC_HI:RT_LO] into opcode, rd, rs, rt
module scu_field_split
  import scu_isa_pkg::*;
(
  input  logic [FIELD_W-1:0] i_fields,
  output logic [OPC_W-1:0]   o_opcode,
  output logic [REG_W-1:0]   o_rd,
  output logic [REG_W-1:0]   o_rs,
  output logic [REG_W-1:0]   o_rt
);
  assign o_opcode = i_fields[OPC_HI-RT_LO -: OPC_W];
  assign o_rd     = i_fields[RD_HI-RT_LO  -: REG_W];
  assign o_rs     = i_fields[RS_HI-RT_LO  -: REG_W];
  assign o_rt     = i_fields[RT_HI-RT_LO  -: REG_W];
endmodule

// File: rtl/if_id_skid_reg.sv
// rtl/if_id_skid_reg.sv - two-entry skid IF/ID register with registered in_ready
// Optional decode-starvation counter on port bubble_cnt: define IFID_BUBBLE_CNT_EN.
module if_id_skid_reg
  import scu_isa_pkg::*;
#(
  parameter int PC_W    = 32,
  parameter int INSTR_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  if_id_skid_reg_if.slave      bus
`ifdef IFID_BUBBLE_CNT_EN
  ,
  output logic [15:0]          bubble_cnt
`endif
);

  skid_state_e        r_state;
  skid_state_e        w_state_nxt;
  logic [PC_W-1:0]    r_main_pc;
  logic [INSTR_W-1:0] r_main_instr;
  logic [PC_W-1:0]    r_skid_pc;
  logic [INSTR_W-1:0] r_skid_instr;
  logic               w_main_valid;
  logic               w_skid_valid;
  logic               w_in_fire;
  logic               w_out_fire;
  logic               w_load_main_in;
  logic               w_load_main_skid;
  logic               w_load_skid;

  assign w_main_valid = r_state[1];
  assign w_skid_valid = r_state[0];
  assign w_in_fire    = bus.in_valid & ~w_skid_valid;
  assign w_out_fire   = w_main_valid & bus.out_ready;

  always_comb begin
    w_state_nxt      = r_state;
    w_load_main_in   = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_in_fire) begin
          w_load_main_in = 1'b1;
          w_state_nxt    = ST_ONE;
        end
      end
      ST_ONE: begin
        if (w_in_fire && w_out_fire) begin
          w_load_main_in = 1'b1;
        end else if (w_in_fire) begin
          w_load_skid = 1'b1;
          w_state_nxt = ST_TWO;
        end else if (w_out_fire) begin
          w_state_nxt = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (w_out_fire) begin
          w_load_main_skid = 1'b1;
          w_state_nxt      = ST_ONE;
        end
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
    // Redirect kills the valid bits only; data registers keep their contents.
    if (flush) begin
      w_state_nxt      = ST_EMPTY;
      w_load_main_in   = 1'b0;
      w_load_main_skid = 1'b0;
      w_load_skid      = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_EMPTY;
      r_main_pc    <= '0;
      r_main_instr <= '0;
      r_skid_pc    <= '0;
      r_skid_instr <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load_main_in) begin
        r_main_pc    <= bus.in_pc;
        r_main_instr <= bus.in_instr;
      end else if (w_load_main_skid) begin
        r_main_pc    <= r_skid_pc;
        r_main_instr <= r_skid_instr;
      end
      if (w_load_skid) begin
        r_skid_pc    <= bus.in_pc;
        r_skid_instr <= bus.in_instr;
      end
    end
  end

  assign bus.in_ready  = ~w_skid_valid;
  assign bus.out_valid = w_main_valid;
  assign bus.out_pc    = r_main_pc;
  assign bus.out_instr = r_main_instr;

  scu_field_split u_field_split (
    .i_fields (r_main_instr[OPC_HI:RT_LO]),
    .o_opcode (bus.out_opcode),
    .o_rd     (bus.out_rd),
    .o_rs     (bus.out_rs),
    .o_rt     (bus.out_rt)
  );

`ifdef IFID_BUBBLE_CNT_EN
  logic [15:0] r_bubble_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bubble_cnt <= '0;
    end else if (bus.out_ready && !w_main_valid && (r_bubble_cnt != 16'hFFFF)) begin
      r_bubble_cnt <= r_bubble_cnt + 16'd1;
    end
  end

  assign bubble_cnt = r_bubble_cnt;
`endif

endmodule

// File: tb/tb_if_id_skid_reg.sv
// tb/tb_if_id_skid_reg.sv - directed self-checking bench for if_id_skid_reg
module tb_if_id_skid_reg;

  logic clk;
  logic reset;
  logic flush;
  int   n_checks;
  int   n_errors;
`ifdef IFID_BUBBLE_CNT_EN
  logic [15:0] bubble_cnt;
`endif

  if_id_skid_reg_if #(.PC_W(32), .INSTR_W(32)) bus ();

  if_id_skid_reg #(.PC_W(32), .INSTR_W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .bus        (bus)
`ifdef IFID_BUBBLE_CNT_EN
    ,
    .bubble_cnt (bubble_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] instr);
    bus.in_valid = v;
    bus.in_pc    = pc;
    bus.in_instr = instr;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    reset         = 1'b0;
    flush         = 1'b0;
    bus.out_ready = 1'b0;
    drive(1'b1, 32'hDEAD, 32'hFFFF_FFFF);
    #1 reset = 1'b1;
    #1;
    check("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
    check("rst_out_pc", {32'd0, bus.out_pc}, 64'd0);
    check("rst_out_instr", {32'd0, bus.out_instr}, 64'd0);
    tick();
    check("rst_ignores_in_valid", {63'd0, bus.out_valid}, 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // Test 1: single word, latency and field split
    drive(1'b1, 32'h10, 32'h9A4C_3C00);
    bus.out_ready = 1'b1;
    tick();
    check("t1_out_valid", {63'd0, bus.out_valid}, 64'd1);
    check("t1_out_pc", {32'd0, bus.out_pc}, 64'h10);
    check("t1_out_instr", {32'd0, bus.out_instr}, 64'h9A4C_3C00);
    check("t1_opcode", {60'd0, bus.out_opcode}, 64'h9);
    check("t1_rd", {58'd0, bus.out_rd}, 64'h29);
    check("t1_rs", {58'd0, bus.out_rs}, 64'h0C);
    check("t1_rt", {58'd0, bus.out_rt}, 64'h0F);
    drive(1'b0, 32'h0, 32'h0);
    tick();
    check("t1_drained", {63'd0, bus.out_valid}, 64'd0);

    // Test 2: fill to TWO with decode stalled, C held off, drain in order
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h100, 32'h1111_0001);
    tick();
    check("t2_a_head", {32'd0, bus.out_pc}, 64'h100);
    check("t2_ready_after_a", {63'd0, bus.in_ready}, 64'd1);
    drive(1'b1, 32'h104, 32'h2222_0002);
    tick();
    check("t2_ready_after_b", {63'd0, bus.in_ready}, 64'd0);
    check("t2_a_stable", {32'd0, bus.out_instr}, 64'h1111_0001);
    drive(1'b1, 32'h108, 32'h3333_0003);
    tick();
    check("t2_c_held_off", {63'd0, bus.in_ready}, 64'd0);
    check("t2_a_still", {32'd0, bus.out_pc}, 64'h100);
    bus.out_ready = 1'b1;
    tick();
    check("t2_b_head", {32'd0, bus.out_pc}, 64'h104);
    check("t2_b_instr", {32'd0, bus.out_instr}, 64'h2222_0002);
    check("t2_ready_back", {63'd0, bus.in_ready}, 64'd1);
    tick();
    check("t2_c_head", {32'd0, bus.out_pc}, 64'h108);
    check("t2_c_valid", {63'd0, bus.out_valid}, 64'd1);
    drive(1'b0, 32'h0, 32'h0);
    tick();
    check("t2_empty", {63'd0, bus.out_valid}, 64'd0);

    // Test 3: flush in TWO together with in_valid
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h200, 32'hAAAA_0000);
    tick();
    drive(1'b1, 32'h204, 32'hBBBB_0000);
    tick();
    check("t3_in_two", {63'd0, bus.in_ready}, 64'd0);
    drive(1'b1, 32'h208, 32'hCCCC_0000);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    check("t3_flush_valid", {63'd0, bus.out_valid}, 64'd0);
    check("t3_flush_ready", {63'd0, bus.in_ready}, 64'd1);
    bus.out_ready = 1'b1;
    tick();
    check("t3_dropped_word", {63'd0, bus.out_valid}, 64'd0);

    // Test 4: back-to-back stream of 8 words
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 32'h300 + 32'(i * 4), 32'h5000_0000 + 32'(i));
      check($sformatf("t4_ready_%0d", i), {63'd0, bus.in_ready}, 64'd1);
      tick();
      check($sformatf("t4_pc_%0d", i), {32'd0, bus.out_pc}, 64'(32'h300 + 32'(i * 4)));
      check($sformatf("t4_valid_%0d", i), {63'd0, bus.out_valid}, 64'd1);
    end
    drive(1'b0, 32'h0, 32'h0);
    tick();
    check("t4_drained", {63'd0, bus.out_valid}, 64'd0);

    // Test 5: asynchronous reset mid-cycle in TWO
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h400, 32'h7777_0000);
    tick();
    drive(1'b1, 32'h404, 32'h8888_0000);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    check("t5_in_two", {63'd0, bus.in_ready}, 64'd0);
    #2 reset = 1'b1;
    #1;
    check("t5_async_valid", {63'd0, bus.out_valid}, 64'd0);
    check("t5_async_ready", {63'd0, bus.in_ready}, 64'd1);
    check("t5_async_pc", {32'd0, bus.out_pc}, 64'd0);
    #1 reset = 1'b0;
    tick();
    check("t5_resume_empty", {63'd0, bus.out_valid}, 64'd0);
    drive(1'b1, 32'h500, 32'h4123_4567);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    check("t5_resume_pc", {32'd0, bus.out_pc}, 64'h500);
    check("t5_resume_opcode", {60'd0, bus.out_opcode}, 64'h4);

`ifdef IFID_BUBBLE_CNT_EN
    // Test 6: bubble counter counting and saturation
    #2 reset = 1'b1;
    #1 reset = 1'b0;
    check("t6_cnt_reset", {48'd0, bubble_cnt}, 64'd0);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check("t6_cnt_5", {48'd0, bubble_cnt}, 64'd5);
    for (int i = 0; i < 65530; i++) tick();
    check("t6_cnt_max", {48'd0, bubble_cnt}, 64'hFFFF);
    tick();
    check("t6_cnt_sat", {48'd0, bubble_cnt}, 64'hFFFF);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
